// File: rtl/smac_stream_addrgen.sv
// Strided word-address generator for one SMAC stream (source a or sink d); first beat one cycle after req_start.
// Holds addr_o/addr_valid_o while addr_ready_i is low. Define SMAC_ADDRGEN_ROLL_EN for feature-counter wrap (feat_roll_i).
module smac_stream_addrgen #(
    parameter int ADDR_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int STRIDE_WIDTH = 16,
    parameter int WORD_BYTES   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    req_start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CNT_WIDTH-1:0]    trans_size_i,
    input  logic [CNT_WIDTH-1:0]    line_length_i,
    input  logic [STRIDE_WIDTH-1:0] line_stride_i,
    input  logic [CNT_WIDTH-1:0]    feat_length_i,
    input  logic [STRIDE_WIDTH-1:0] feat_stride_i,
`ifdef SMAC_ADDRGEN_ROLL_EN
    input  logic [CNT_WIDTH-1:0]    feat_roll_i,
`endif
    output logic                    ready_start_o,
    output logic                    done_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic [ADDR_WIDTH-1:0]   addr_o
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [ADDR_WIDTH-1:0] WORD_INC = ADDR_WIDTH'(WORD_BYTES);

    state_e                  state_q, state_d;
    logic                    done_q, done_d;

    logic [CNT_WIDTH-1:0]    trans_size_q;
    logic [CNT_WIDTH-1:0]    line_last_q;
    logic [CNT_WIDTH-1:0]    feat_last_q;
    logic [ADDR_WIDTH-1:0]   line_stride_q;
    logic [ADDR_WIDTH-1:0]   feat_stride_q;

    logic [CNT_WIDTH-1:0]    word_idx_q;
    logic [CNT_WIDTH-1:0]    line_idx_q;
    logic [CNT_WIDTH-1:0]    beat_cnt_q;
    logic [ADDR_WIDTH-1:0]   line_off_q;
    logic [ADDR_WIDTH-1:0]   feat_base_q;

`ifdef SMAC_ADDRGEN_ROLL_EN
    logic [ADDR_WIDTH-1:0]   base_addr_q;
    logic [CNT_WIDTH-1:0]    feat_roll_q;
    logic [CNT_WIDTH-1:0]    feat_idx_q;
`endif

    logic start_acc;
    logic xfer;
    logic last_beat;
    logic word_end;
    logic line_end;

    assign start_acc = (state_q == IDLE) && req_start_i && !clear_i;
    assign xfer      = (state_q == RUN) && addr_ready_i;
    assign last_beat = xfer && (beat_cnt_q == trans_size_q - CNT_WIDTH'(1));
    assign word_end  = (word_idx_q == line_last_q);
    assign line_end  = (line_idx_q == feat_last_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_start_i) begin
                        // A zero-length transfer completes without entering RUN.
                        if (trans_size_i == '0) done_d  = 1'b1;
                        else                    state_d = RUN;
                    end
                end
                RUN: begin
                    if (last_beat) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trans_size_q  <= '0;
            line_last_q   <= '0;
            feat_last_q   <= '0;
            line_stride_q <= '0;
            feat_stride_q <= '0;
            word_idx_q    <= '0;
            line_idx_q    <= '0;
            beat_cnt_q    <= '0;
            line_off_q    <= '0;
            feat_base_q   <= '0;
`ifdef SMAC_ADDRGEN_ROLL_EN
            base_addr_q   <= '0;
            feat_roll_q   <= '0;
            feat_idx_q    <= '0;
`endif
        end else if (clear_i) begin
            trans_size_q  <= '0;
            line_last_q   <= '0;
            feat_last_q   <= '0;
            line_stride_q <= '0;
            feat_stride_q <= '0;
            word_idx_q    <= '0;
            line_idx_q    <= '0;
            beat_cnt_q    <= '0;
            line_off_q    <= '0;
            feat_base_q   <= '0;
`ifdef SMAC_ADDRGEN_ROLL_EN
            base_addr_q   <= '0;
            feat_roll_q   <= '0;
            feat_idx_q    <= '0;
`endif
        end else if (start_acc) begin
            // Lengths of 0 behave as 1, so store the last valid index directly.
            trans_size_q  <= trans_size_i;
            line_last_q   <= (line_length_i == '0) ? '0 : line_length_i - CNT_WIDTH'(1);
            feat_last_q   <= (feat_length_i == '0) ? '0 : feat_length_i - CNT_WIDTH'(1);
            line_stride_q <= ADDR_WIDTH'(line_stride_i);
            feat_stride_q <= ADDR_WIDTH'(feat_stride_i);
            word_idx_q    <= '0;
            line_idx_q    <= '0;
            beat_cnt_q    <= '0;
            line_off_q    <= '0;
            feat_base_q   <= base_addr_i;
`ifdef SMAC_ADDRGEN_ROLL_EN
            base_addr_q   <= base_addr_i;
            feat_roll_q   <= feat_roll_i;
            feat_idx_q    <= '0;
`endif
        end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            if (!word_end) begin
                word_idx_q <= word_idx_q + CNT_WIDTH'(1);
            end else begin
                word_idx_q <= '0;
                if (!line_end) begin
                    line_idx_q <= line_idx_q + CNT_WIDTH'(1);
                    line_off_q <= line_off_q + line_stride_q;
                end else begin
                    line_idx_q <= '0;
                    line_off_q <= '0;
`ifdef SMAC_ADDRGEN_ROLL_EN
                    if ((feat_roll_q != '0) && (feat_idx_q == feat_roll_q - CNT_WIDTH'(1))) begin
                        feat_idx_q  <= '0;
                        feat_base_q <= base_addr_q;
                    end else begin
                        feat_idx_q  <= feat_idx_q + CNT_WIDTH'(1);
                        feat_base_q <= feat_base_q + feat_stride_q;
                    end
`else
                    feat_base_q <= feat_base_q + feat_stride_q;
`endif
                end
            end
        end
    end

    assign ready_start_o = (state_q == IDLE);
    assign addr_valid_o  = (state_q == RUN);
    assign done_o        = done_q;
    assign addr_o        = (state_q == RUN)
                         ? feat_base_q + line_off_q + ADDR_WIDTH'(word_idx_q) * WORD_INC
                         : '0;

endmodule

// File: tb/tb_smac_stream_addrgen.sv
// Scoreboard bench for smac_stream_addrgen: expected addresses queued at start, popped on each accepted beat.
module tb_smac_stream_addrgen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        req_start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] trans_size_i = '0;
    logic [15:0] line_length_i = '0;
    logic [15:0] line_stride_i = '0;
    logic [15:0] feat_length_i = '0;
    logic [15:0] feat_stride_i = '0;
    logic [15:0] feat_roll_i = '0;
    logic        ready_start_o;
    logic        done_o;
    logic        addr_valid_o;
    logic        addr_ready_i = 1'b1;
    logic [31:0] addr_o;

    smac_stream_addrgen dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .req_start_i   (req_start_i),
        .base_addr_i   (base_addr_i),
        .trans_size_i  (trans_size_i),
        .line_length_i (line_length_i),
        .line_stride_i (line_stride_i),
        .feat_length_i (feat_length_i),
        .feat_stride_i (feat_stride_i),
`ifdef SMAC_ADDRGEN_ROLL_EN
        .feat_roll_i   (feat_roll_i),
`endif
        .ready_start_o (ready_start_o),
        .done_o        (done_o),
        .addr_valid_o  (addr_valid_o),
        .addr_ready_i  (addr_ready_i),
        .addr_o        (addr_o)
    );

    always #5 clk_i = ~clk_i;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          xfer_cnt, done_cnt, low_cnt, valid_seen, last_cyc, done_cyc, start_cyc;
    logic        stall_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_mode) begin
                addr_ready_i = (k % 3 == 0);
                k++;
            end else begin
                addr_ready_i = 1'b1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (!ready_start_o) low_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (addr_valid_o) valid_seen++;
            if (stall_prev) begin
                chk("hold_vld", {31'b0, addr_valid_o}, 32'd1);
                chk("hold_addr", addr_o, prev_addr);
            end
            stall_prev = addr_valid_o && !addr_ready_i;
            prev_addr  = addr_o;
            if (addr_valid_o && addr_ready_i) begin
                if (exp_q.size() == 0) chk("extra_beat", addr_o, 32'hDEAD_BEEF);
                else                   chk("addr", addr_o, exp_q.pop_front());
                xfer_cnt++;
                last_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        xfer_cnt = 0; done_cnt = 0; low_cnt = 0; valid_seen = 0;
        last_cyc = -1; done_cyc = -1;
    endtask

    // Reference: nested word/line/feature loops computed from the beat number.
    task automatic start(input logic [31:0] base, input int ts, input int ll, input int ls,
                         input int fl, input int fs, input int roll);
        int wl, fll, w, l, f;
        clear_stats();
        wl  = (ll == 0) ? 1 : ll;
        fll = (fl == 0) ? 1 : fl;
        for (int b = 0; b < ts; b++) begin
            w = b % wl;
            l = (b / wl) % fll;
            f = b / (wl * fll);
`ifdef SMAC_ADDRGEN_ROLL_EN
            if (roll != 0) f = f % roll;
`endif
            exp_q.push_back(base + 32'(f * fs) + 32'(l * ls) + 32'(w * 4));
        end
        @(posedge clk_i);
        #1;
        base_addr_i = base; trans_size_i = 16'(ts); line_length_i = 16'(ll);
        line_stride_i = 16'(ls); feat_length_i = 16'(fl); feat_stride_i = 16'(fs);
        feat_roll_i = 16'(roll);
        req_start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i);
        #1;
        req_start_i = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done_cnt == 0 && n < max) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        chk("done_timeout", {31'b0, done_cnt != 0}, 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'b0, ready_start_o}, 32'd1);
        chk("rst_valid", {31'b0, addr_valid_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_addr", addr_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Linear line; a start pulse mid-run must be ignored.
        start(32'h1000, 4, 4, 0, 1, 0, 0);
        @(posedge clk_i); #1;
        req_start_i = 1'b1; base_addr_i = 32'h9000; trans_size_i = 16'd9;
        @(posedge clk_i); #1;
        req_start_i = 1'b0;
        wait_done(30);
        chk("t1_xfers", 32'(xfer_cnt), 32'd4);
        chk("t1_first_cyc", 32'(last_cyc - 3), 32'(start_cyc + 1));
        chk("t1_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        chk("t1_low", 32'(low_cnt), 32'd4);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Two words per line, three lines per feature.
        start(32'h2000, 6, 2, 32'h40, 3, 0, 0);
        wait_done(40);
        chk("t2_xfers", 32'(xfer_cnt), 32'd6);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Multi-feature walk with zero lengths treated as one.
        start(32'hFFFF_FFF0, 5, 0, 32'h100, 0, 32'h8, 0);
        wait_done(40);
        chk("t2b_xfers", 32'(xfer_cnt), 32'd5);
        chk("t2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure.
        stall_mode = 1'b1;
        start(32'h1000, 4, 4, 0, 1, 0, 0);
        wait_done(60);
        stall_mode = 1'b0;
        chk("t3_xfers", 32'(xfer_cnt), 32'd4);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length transfer.
        start(32'h4000, 0, 4, 0, 1, 0, 0);
        wait_done(20);
        chk("t4_valid", 32'(valid_seen), 32'd0);
        chk("t4_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
        chk("t4_low", 32'(low_cnt), 32'd0);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // Reset during the third beat.
        start(32'h1000, 8, 8, 0, 1, 0, 0);
        begin
            int n;
            n = 0;
            while (xfer_cnt < 2 && n < 20) begin
                @(negedge clk_i);
                #1;
                n++;
            end
        end
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        chk("t5_rst_ready", {31'b0, ready_start_o}, 32'd1);
        chk("t5_rst_valid", {31'b0, addr_valid_o}, 32'd0);
        chk("t5_rst_addr", addr_o, 32'd0);
        chk("t5_rst_done", {31'b0, done_o}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        start(32'h3000, 1, 1, 0, 1, 0, 0);
        wait_done(20);
        chk("t5_xfers", 32'(xfer_cnt), 32'd1);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        // Soft clear mid-run.
        start(32'h5000, 8, 8, 0, 1, 0, 0);
        @(posedge clk_i); #1;
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        chk("t6_clr_ready", {31'b0, ready_start_o}, 32'd1);
        chk("t6_clr_valid", {31'b0, addr_valid_o}, 32'd0);
        chk("t6_clr_addr", addr_o, 32'd0);
        exp_q.delete();
        repeat (4) @(negedge clk_i);
        chk("t6_no_done", 32'(done_cnt), 32'd0);

`ifdef SMAC_ADDRGEN_ROLL_EN
        start(32'h0, 6, 1, 0, 1, 32'h10, 3);
        wait_done(40);
        chk("t7_xfers", 32'(xfer_cnt), 32'd6);
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
